// File: rtl/wb_sram_pkg.sv
// Shared definitions for the Wishbone-to-OpenRAM program-store bridge:
// FSM state encoding, control register bit positions and window geometry.
package wb_sram_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RAM_ACC  = 2'd1,
        RAM_WAIT = 2'd2,
        ACK      = 2'd3
    } state_t;

    // Control register bit positions
    localparam int RUN_BIT  = 0;
    localparam int VIOL_BIT = 1;

    // SRAM word address width (512 words of 32 bits)
    localparam int RAM_AW = 9;

    // The bridge decodes a 4 kB window; the lower 2 kB map onto the SRAM
    localparam int WIN_AW = 12;
    localparam logic [WIN_AW-1:0] RAM_BYTES = 12'h800;

    // True when the address falls inside the 4 kB window at base
    function automatic logic in_window(input logic [31:0] adr, input logic [31:0] base);
        return adr[31:WIN_AW] == base[31:WIN_AW];
    endfunction

endpackage

// File: rtl/wb_sram_bridge.sv
// Wishbone classic slave that sequences port 0 of the 32x512 OpenRAM
// program store and exposes a control register whose run bit releases the
// TMS1x00 core from reset.
// Optional build macro: WB_SRAM_WRPROT_EN -- blocks RAM writes while run=1
// and records them in a sticky viol bit (CTRL bit1).
module wb_sram_bridge
    import wb_sram_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
    parameter logic [11:0] CTRL_OFFSET = 12'h800
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        ram_csb,
    output logic        ram_web,
    output logic [3:0]  ram_wmask,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0] ram_din,
    input  logic [31:0] ram_dout,
    output logic        core_rst_o
);

    state_t            state;
    logic              is_wr;
    logic              run;
    logic              viol;
    logic              core_rst;

    logic [WIN_AW-1:0] offset;
    logic              req;
    logic              is_ram;
    logic              is_ctrl;
    logic              ctrl_wr;
    logic              blocked;
    logic [31:0]       ctrl_rdata;
    logic              unused_adr_bits;

    assign offset  = wbs_adr_i[WIN_AW-1:0];
    assign req     = (state == IDLE) & wbs_cyc_i & wbs_stb_i & in_window(wbs_adr_i, BASE_ADDR);
    assign is_ram  = offset < RAM_BYTES;
    assign is_ctrl = offset == CTRL_OFFSET;
    assign ctrl_wr = req & is_ctrl & wbs_we_i;

    // Byte-lane bits of the address are irrelevant for word accesses
    assign unused_adr_bits = ^wbs_adr_i[1:0];

`ifdef WB_SRAM_WRPROT_EN
    logic set_viol;
    logic clr_viol;

    // RAM writes are refused while the core is running
    assign blocked  = run & wbs_we_i;
    assign set_viol = req & is_ram & blocked;
    assign clr_viol = ctrl_wr & wbs_dat_i[VIOL_BIT];

    // Sticky violation flag; a clear request beats a same-cycle set
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            viol <= 1'b0;
        end else begin
            viol <= (viol | set_viol) & ~clr_viol;
        end
    end
`else
    assign blocked = 1'b0;
    assign viol    = 1'b0;
`endif

    // Read view of the control register; unused bits read as zero
    always_comb begin
        ctrl_rdata           = '0;
        ctrl_rdata[RUN_BIT]  = run;
        ctrl_rdata[VIOL_BIT] = viol;
    end

    // Run bit, written through the control register
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            run <= 1'b0;
        end else if (ctrl_wr) begin
            run <= wbs_dat_i[RUN_BIT];
        end
    end

    // Core reset follows run one cycle later so it comes straight from a flop
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            core_rst <= 1'b1;
        end else begin
            core_rst <= ~run;
        end
    end

    assign core_rst_o = core_rst;

    // Access sequencer: all bus and RAM outputs are registered here
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state     <= IDLE;
            is_wr     <= 1'b0;
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
            ram_csb   <= 1'b1;
            ram_web   <= 1'b1;
            ram_wmask <= '0;
            ram_addr  <= '0;
            ram_din   <= '0;
        end else begin
            wbs_ack_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        if (is_ram) begin
                            ram_csb   <= blocked;
                            ram_web   <= ~wbs_we_i;
                            ram_wmask <= wbs_we_i ? wbs_sel_i : 4'b0000;
                            ram_addr  <= wbs_adr_i[RAM_AW+1:2];
                            ram_din   <= wbs_dat_i;
                            is_wr     <= wbs_we_i;
                            state     <= RAM_ACC;
                        end else begin
                            // Register or unmapped access completes at once
                            if (!wbs_we_i) begin
                                wbs_dat_o <= is_ctrl ? ctrl_rdata : 32'h0;
                            end
                            wbs_ack_o <= 1'b1;
                            state     <= ACK;
                        end
                    end
                end
                RAM_ACC: begin
                    ram_csb <= 1'b1;
                    ram_web <= 1'b1;
                    if (!wbs_cyc_i) begin
                        state <= IDLE;
                    end else if (is_wr) begin
                        wbs_ack_o <= 1'b1;
                        state     <= ACK;
                    end else begin
                        state <= RAM_WAIT;
                    end
                end
                RAM_WAIT: begin
                    if (!wbs_cyc_i) begin
                        state <= IDLE;
                    end else begin
                        wbs_dat_o <= ram_dout;
                        wbs_ack_o <= 1'b1;
                        state     <= ACK;
                    end
                end
                default: begin
                    // ACK: the acknowledge pulse is on during this state
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_sram_bridge.sv
// Self-checking bench for wb_sram_bridge: directed scenarios followed by
// randomized Wishbone traffic checked against a transaction-level model.
module tb_wb_sram_bridge;

    localparam logic [31:0] BASE = 32'h3000_0000;
`ifdef WB_SRAM_WRPROT_EN
    localparam bit WRPROT = 1'b1;
`else
    localparam bit WRPROT = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, dat_w;
    logic        ack;
    logic [31:0] dat_r;
    logic        csb, web;
    logic [3:0]  wmask;
    logic [8:0]  raddr;
    logic [31:0] din;
    logic [31:0] dout;
    logic        core_rst;

    int total = 0;
    int bad   = 0;

    // SRAM behavioural model (environment) and reference state
    logic [31:0] sram [0:511];
    logic [31:0] ref_mem [0:511];
    bit          ref_run;
    bit          ref_viol;
    logic [31:0] ref_dat;

    // Observations captured during the most recent bus access
    bit          csb_seen_low;
    logic [8:0]  snap_addr;
    logic [3:0]  snap_wmask;

    wb_sram_bridge dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .wbs_cyc_i  (cyc),
        .wbs_stb_i  (stb),
        .wbs_we_i   (we),
        .wbs_sel_i  (sel),
        .wbs_adr_i  (adr),
        .wbs_dat_i  (dat_w),
        .wbs_ack_o  (ack),
        .wbs_dat_o  (dat_r),
        .ram_csb    (csb),
        .ram_web    (web),
        .ram_wmask  (wmask),
        .ram_addr   (raddr),
        .ram_din    (din),
        .ram_dout   (dout),
        .core_rst_o (core_rst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // OpenRAM port-0 style model: synchronous write, registered read
    always @(posedge clk) begin
        if (!csb) begin
            if (!web) begin
                for (int b = 0; b < 4; b++)
                    if (wmask[b]) sram[raddr][8*b +: 8] <= din[8*b +: 8];
            end else begin
                dout <= sram[raddr];
            end
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    // One Wishbone classic access; waits at most 10 cycles for ack
    task automatic bus(input bit w, input logic [3:0] s, input logic [31:0] a, input logic [31:0] d,
                       output bit acked, output int lat, output logic [31:0] rdata);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; sel = s; adr = a; dat_w = d;
        acked = 1'b0; lat = 0; rdata = '0; csb_seen_low = 1'b0;
        for (int i = 1; i <= 10 && !acked; i++) begin
            @(posedge clk); #1;
            if (!csb) csb_seen_low = 1'b1;
            if (i == 1) begin
                snap_addr  = raddr;
                snap_wmask = wmask;
            end
            if (ack) begin
                acked = 1'b1;
                lat   = i;
                rdata = dat_r;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    // Access plus checks against the reference model, then model update
    task automatic do_txn(input bit w, input logic [3:0] s, input logic [31:0] a, input logic [31:0] d);
        bit          hit, is_ram, is_ctrl, blk, acked;
        int          lat, exp_lat;
        logic [31:0] rd, exp_rd;
        logic [8:0]  wd;
        hit     = a[31:12] == BASE[31:12];
        is_ram  = hit && (a[11:0] < 12'h800);
        is_ctrl = hit && (a[11:0] == 12'h800);
        wd      = a[10:2];
        blk     = WRPROT && ref_run && w;
        exp_rd  = ref_dat;
        if (!hit)        exp_lat = 0;
        else if (is_ram) exp_lat = w ? 2 : 3;
        else             exp_lat = 1;
        if (hit && !w) begin
            if (is_ram)       exp_rd = ref_mem[wd];
            else if (is_ctrl) exp_rd = {30'b0, ref_viol, ref_run};
            else              exp_rd = 32'h0;
        end

        bus(w, s, a, d, acked, lat, rd);
        $display("txn we=%0b sel=%h adr=%08h dat=%08h ack=%0b lat=%0d rd=%08h",
                 w, s, a, d, acked, lat, rd);

        check_val("ack", {31'b0, acked}, {31'b0, hit});
        if (acked && hit) begin
            check_val("latency", lat, exp_lat);
            check_val("rdata", rd, exp_rd);
        end
        if (is_ram) begin
            check_val("csb_issued", {31'b0, csb_seen_low}, {31'b0, !blk});
            if (!blk) begin
                check_val("ram_addr", {23'b0, snap_addr}, {23'b0, wd});
                check_val("ram_wmask", {28'b0, snap_wmask}, {28'b0, (w ? s : 4'b0000)});
            end
        end

        ref_dat = exp_rd;
        if (hit && w) begin
            if (is_ram) begin
                if (blk) ref_viol = 1'b1;
                else
                    for (int b = 0; b < 4; b++)
                        if (s[b]) ref_mem[wd][8*b +: 8] = d[8*b +: 8];
            end else if (is_ctrl) begin
                ref_run = d[0];
                if (WRPROT && d[1]) ref_viol = 1'b0;
            end
        end

        @(posedge clk); #1;
        check_val("core_rst", {31'b0, core_rst}, {31'b0, !ref_run});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          acks;
        int          r;
        bit          rw;
        logic [31:0] a;

        for (int i = 0; i < 512; i++) begin
            sram[i]    = 32'h0;
            ref_mem[i] = 32'h0;
        end
        ref_run = 0; ref_viol = 0; ref_dat = 32'h0;
        dout = 32'h0;
        cyc = 0; stb = 0; we = 0; sel = 4'h0; adr = 32'h0; dat_w = 32'h0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_val("rst_ack", {31'b0, ack}, 32'h0);
        check_val("rst_csb", {31'b0, csb}, 32'h1);
        check_val("rst_core_rst", {31'b0, core_rst}, 32'h1);
        check_val("rst_dat", dat_r, 32'h0);

        // Control register after reset
        do_txn(1'b0, 4'hF, BASE + 32'h800, 32'h0);

        // Full-word write and read back, then byte-lane merge
        do_txn(1'b1, 4'hF, BASE + 32'h10, 32'hDEADBEEF);
        do_txn(1'b0, 4'hF, BASE + 32'h10, 32'h0);
        do_txn(1'b1, 4'b0010, BASE + 32'h10, 32'h0000AA00);
        do_txn(1'b0, 4'hF, BASE + 32'h10, 32'h0);
        check_val("merged_word", ref_dat, 32'hDEADAAEF);

        // Miss outside the window, then a normal access from IDLE
        do_txn(1'b0, 4'hF, 32'h3100_0000, 32'h0);
        do_txn(1'b0, 4'hF, BASE + 32'h800, 32'h0);

        // Last RAM word: read abandoned right after the request
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = BASE + 32'h7FC;
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0;
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (ack) acks++;
        end
        check_val("drop_no_ack", acks, 0);
        do_txn(1'b1, 4'hF, BASE + 32'h7FC, 32'h1234_5678);
        do_txn(1'b0, 4'hF, BASE + 32'h7FC, 32'h0);

        // Unmapped offset inside the window
        do_txn(1'b1, 4'hF, BASE + 32'hC00, 32'hFFFF_FFFF);
        do_txn(1'b0, 4'hF, BASE + 32'hC00, 32'h0);

        // Release the core, then write RAM while running
        do_txn(1'b1, 4'hF, BASE + 32'h800, 32'h1);
        do_txn(1'b1, 4'hF, BASE + 32'h0, 32'hCAFE_F00D);
        do_txn(1'b0, 4'hF, BASE + 32'h800, 32'h0);
        do_txn(1'b1, 4'hF, BASE + 32'h800, 32'h3);
        do_txn(1'b0, 4'hF, BASE + 32'h800, 32'h0);
        do_txn(1'b0, 4'hF, BASE + 32'h0, 32'h0);

        // Randomized traffic
        for (int n = 0; n < 150; n++) begin
            r  = $urandom_range(0, 19);
            rw = $urandom_range(0, 1);
            if (r < 11)       a = BASE + {$urandom_range(0, 15), 2'b00};
            else if (r == 11) a = BASE + 32'h7FC;
            else if (r < 15)  a = BASE + 32'h800;
            else if (r < 18)  a = BASE + {$urandom_range(32'h201, 32'h3FF), 2'b00};
            else if (r == 18) a = 32'h2000_0000 + {$urandom_range(0, 1023), 2'b00};
            else              a = BASE;
            do_txn(rw, 4'($urandom_range(1, 15)), a, $urandom);
        end

        // Reset asserted in the middle of a RAM write
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; adr = BASE + 32'h40; dat_w = 32'h5555_AAAA;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check_val("midrst_csb", {31'b0, csb}, 32'h1);
        check_val("midrst_web", {31'b0, web}, 32'h1);
        check_val("midrst_ack", {31'b0, ack}, 32'h0);
        check_val("midrst_dat", dat_r, 32'h0);
        check_val("midrst_core_rst", {31'b0, core_rst}, 32'h1);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        ref_run = 0; ref_viol = 0; ref_dat = 32'h0;
        do_txn(1'b0, 4'hF, BASE + 32'h800, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
